// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART-style receive sequencer driving an external shift register,
// with start-bit qualification, stop-bit check and ready/overrun/framing flags.
module rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic rx_busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START_CHK, RECV, STOP_CHK, LOAD} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [CW-1:0] bit_cnt;
  logic sync1, sync2, hist;
  logic fall;
  assign fall = hist & ~sync2;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      hist          <= 1'b1;
      shift_strobe  <= 1'b0;
      load_buffer   <= 1'b0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      sync1        <= serial_in;
      sync2        <= sync1;
      hist         <= sync2;
      shift_strobe <= 1'b0;
      load_buffer  <= 1'b0;
      // A load always wins over a read; a read during a load neither clears nor flags.
      if (load_buffer) begin
        if (data_ready && !data_read) overrun_error <= 1'b1;
        data_ready <= 1'b1;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (state)
        IDLE: if (fall) begin
          state         <= START_CHK;
          timer         <= '0;
          bit_cnt       <= '0;
          framing_error <= 1'b0;
          rx_busy       <= 1'b1;
        end
        START_CHK: if (timer == HALF) begin
          timer   <= '0;
          state   <= sync2 ? IDLE : RECV;
          rx_busy <= ~sync2;
        end else timer <= timer + 1'b1;
        RECV: begin
          timer        <= (timer == LAST) ? '0 : timer + 1'b1;
          shift_strobe <= (timer == PRE);
          if (timer == LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP_CHK;
          end
        end
        STOP_CHK: if (stop_bit) begin
          state       <= LOAD;
          load_buffer <= 1'b1;
        end else begin
          state         <= IDLE;
          framing_error <= 1'b1;
          rx_busy       <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed and random frames against a behavioural flag model
// and a bench-side 9-bit shift register fed by shift_strobe.
module tb_rx_frame_ctrl;
  localparam int C = 10;
  logic clk = 1'b0, n_rst = 1'b0, serial_in = 1'b1, data_read = 1'b0;
  logic stop_bit, shift_strobe, load_buffer, data_ready, framing_error, overrun_error, rx_busy;
  logic [8:0] sr = '1;
  int cyc = 0;
  int strobe_t[$];
  logic [7:0] loads[$];
  int npass = 0, nfail = 0, ntot = 0;
  bit m_rdy = 0, m_ovr = 0, m_fe = 0;

  rx_frame_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .stop_bit(stop_bit),
    .data_read(data_read), .shift_strobe(shift_strobe), .load_buffer(load_buffer),
    .data_ready(data_ready), .framing_error(framing_error),
    .overrun_error(overrun_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  assign stop_bit = sr[8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift_strobe) begin
      sr <= {serial_in, sr[8:1]};
      strobe_t.push_back(cyc);
    end
    if (load_buffer) loads.push_back(sr[7:0]);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ready"}, data_ready, m_rdy);
    chk({tag, "_overrun"}, overrun_error, m_ovr);
    chk({tag, "_framing"}, framing_error, m_fe);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobe"}, shift_strobe, 0);
    chk({tag, "_load"}, load_buffer, 0);
    chk({tag, "_ready"}, data_ready, 0);
    chk({tag, "_framing"}, framing_error, 0);
    chk({tag, "_overrun"}, overrun_error, 0);
    chk({tag, "_busy"}, rx_busy, 0);
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit ack_load,
                      input int abort_n, output bit aborted);
    logic [9:0] bits;
    int s0;
    bits = {stop, d, 1'b0};
    s0 = strobe_t.size();
    aborted = 0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        serial_in = bits[b];
        data_read = ack_load && load_buffer;
        if (abort_n > 0 && strobe_t.size() - s0 >= abort_n) begin
          aborted = 1;
          data_read = 0;
          return;
        end
      end
    @(negedge clk);
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (C) @(negedge clk);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input bit stop, input bit ack_load);
    int s0, l0;
    bit ab;
    s0 = strobe_t.size();
    l0 = loads.size();
    send(d, stop, ack_load, 0, ab);
    m_fe = 0;
    if (stop) begin
      if (m_rdy && !ack_load) m_ovr = 1;
      m_rdy = 1;
    end else m_fe = 1;
    chk({tag, "_strobes"}, strobe_t.size() - s0, 9);
    for (int i = s0 + 1; i < strobe_t.size(); i++)
      chk({tag, "_spacing"}, strobe_t[i] - strobe_t[i-1], C);
    chk({tag, "_loads"}, loads.size() - l0, int'(stop));
    if (stop && loads.size() > l0) chk({tag, "_byte"}, loads[l0], d);
    chk_flags(tag);
    chk({tag, "_busy"}, rx_busy, 0);
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_rdy = 0;
    m_ovr = 0;
    chk_flags(tag);
  endtask

  initial begin
    int s0, l0;
    bit ab;
    logic [7:0] d;
    bit stop;
    int mode;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("idle_busy", rx_busy, 0);

    frame("a5", 8'hA5, 1, 0);
    frame("3c_badstop", 8'h3C, 0, 0);

    // Short low pulse: start qualification rejects it, but the edge still clears framing_error.
    s0 = strobe_t.size();
    l0 = loads.size();
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", rx_busy, 1);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    m_fe = 0;
    chk("glitch_busy_lo", rx_busy, 0);
    chk("glitch_strobes", strobe_t.size() - s0, 0);
    chk("glitch_loads", loads.size() - l0, 0);
    chk_flags("glitch");
    ack("ack1");

    frame("f11", 8'h11, 1, 0);
    frame("f22_overrun", 8'h22, 1, 0);
    ack("ack2");
    frame("f11b", 8'h11, 1, 0);
    frame("f22_readload", 8'h22, 1, 1);
    frame("f33_overrun", 8'h33, 1, 0);

    s0 = strobe_t.size();
    l0 = loads.size();
    send(8'h5A, 1, 0, 4, ab);
    chk("abort_hit", ab, 1);
    chk("abort_strobes", strobe_t.size() - s0, 4);
    serial_in = 1'b1;
    n_rst = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    n_rst = 1'b1;
    m_rdy = 0;
    m_ovr = 0;
    m_fe = 0;
    repeat (2 * C) @(negedge clk);
    chk("abort_loads", loads.size() - l0, 0);
    chk("abort_busy", rx_busy, 0);
    frame("f5a", 8'h5A, 1, 0);

    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 2);
      frame("rand", d, stop, mode == 1);
      if (mode == 2) ack("rand_ack");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
